// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types for the dcache snoop responder: frame layout and the snoop FSM state encoding.
package dcache_snoop_responder_pkg;

   localparam int DC_TAG_W = 26;
   localparam int DC_IDX_W = 3;

   typedef logic [31:0] word_t;

   // One cache frame as seen on the dcache array read ports; data1 is word 0, data2 is word 1.
   typedef struct packed {
      logic                valid;
      logic                dirty;
      logic [DC_TAG_W-1:0] tag;
      word_t               data1;
      word_t               data2;
   } Dcache_t;

   typedef enum logic [2:0] {
      SNP_IDLE,
      SNP_LOOKUP,
      SNP_SUP1,
      SNP_SUP2,
      SNP_UPD,
      SNP_DONE
   } Snoop_state_t;

endpackage

// File: rtl/dcache_snoop_responder_tag_match.sv
// Two-way combinational tag compare for a snooped block; way0 wins if both ways claim the block.
module snoop_tag_match #(
   parameter int TAG_W = 26
) (
   input  logic             valid0_i,
   input  logic             dirty0_i,
   input  logic [TAG_W-1:0] tag0_i,
   input  logic             valid1_i,
   input  logic             dirty1_i,
   input  logic [TAG_W-1:0] tag1_i,
   input  logic [TAG_W-1:0] snoopTag_i,
   output logic             hit0_o,
   output logic             hit1_o,
   output logic             dirty_o,
   output logic             way_o
);

   // An invalid frame never hits, so a stale dirty bit on it is ignored.
   assign hit0_o  = valid0_i && (tag0_i == snoopTag_i);
   assign hit1_o  = valid1_i && (tag1_i == snoopTag_i);
   assign way_o   = !hit0_o && hit1_o;
   assign dirty_o = hit0_o ? dirty0_i : (hit1_o ? dirty1_i : 1'b0);

endmodule

// File: rtl/dcache_snoop_responder.sv
// Cache side of the coherence snoop: look up the snooped block, stream a dirty block to the bus,
// then clean or invalidate the hit frame while the dcache FSM is parked.
module dcache_snoop_responder
   import dcache_snoop_responder_pkg::*;
#(
   parameter int TAG_W = DC_TAG_W,
   parameter int IDX_W = DC_IDX_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ccwait,
   input  logic [31:0]      ccsnoopaddr,
   input  logic             ccinv,
   input  logic             ccdwait,
   output logic [IDX_W-1:0] snp_idx,
   input  Dcache_t          way0_frame,
   input  Dcache_t          way1_frame,
   output logic             cchit,
   output logic             cctrans,
   output logic             ccwrite,
   output logic [31:0]      ccdata,
   output logic             snp_upd_en,
   output logic             snp_way,
   output logic             snp_valid_nx,
   output logic             snp_dirty_nx,
   output logic             ccdone
);

   Snoop_state_t state_q;
   logic         cchit_q;
   logic         cctrans_q;
   logic         snpWay_q;

   logic         hit0;
   logic         hit1;
   logic         hitDirty;
   logic         hitWay;
   logic         anyHit;
   Dcache_t      supplyFrame;
   logic         unusedAddrBits;

   assign snp_idx        = ccsnoopaddr[IDX_W+2:3];
   assign unusedAddrBits = ^ccsnoopaddr[2:0];

   snoop_tag_match #(
      .TAG_W(TAG_W)
   ) u_tag_match (
      .valid0_i  (way0_frame.valid),
      .dirty0_i  (way0_frame.dirty),
      .tag0_i    (way0_frame.tag),
      .valid1_i  (way1_frame.valid),
      .dirty1_i  (way1_frame.dirty),
      .tag1_i    (way1_frame.tag),
      .snoopTag_i(ccsnoopaddr[31 -: TAG_W]),
      .hit0_o    (hit0),
      .hit1_o    (hit1),
      .dirty_o   (hitDirty),
      .way_o     (hitWay)
   );

   assign anyHit = hit0 || hit1;

   // Any drop of ccwait before DONE abandons the snoop; the hit frame is left untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= SNP_IDLE;
         cchit_q   <= 1'b0;
         cctrans_q <= 1'b0;
         snpWay_q  <= 1'b0;
      end else if (!ccwait && state_q != SNP_IDLE) begin
         state_q   <= SNP_IDLE;
         cchit_q   <= 1'b0;
         cctrans_q <= 1'b0;
         snpWay_q  <= 1'b0;
      end else begin
         case (state_q)
            SNP_IDLE: begin
               if (ccwait) state_q <= SNP_LOOKUP;
            end
            SNP_LOOKUP: begin
               cchit_q   <= anyHit;
               cctrans_q <= anyHit && hitDirty;
               snpWay_q  <= hitWay;
               if (!anyHit)       state_q <= SNP_DONE;
               else if (hitDirty) state_q <= SNP_SUP1;
               else               state_q <= SNP_UPD;
            end
            SNP_SUP1: begin
               if (!ccdwait) state_q <= SNP_SUP2;
            end
            SNP_SUP2: begin
               if (!ccdwait) state_q <= SNP_UPD;
            end
            SNP_UPD: begin
               state_q <= SNP_DONE;
            end
            SNP_DONE: begin
               state_q <= SNP_DONE;
            end
            default: begin
               state_q <= SNP_IDLE;
            end
         endcase
      end
   end

   // Supplied words come straight off the array read port every cycle, word 0 first.
   assign supplyFrame = snpWay_q ? way1_frame : way0_frame;
   assign ccwrite     = (state_q == SNP_SUP1) || (state_q == SNP_SUP2);
   assign ccdata      = (state_q == SNP_SUP1) ? supplyFrame.data1 :
                        (state_q == SNP_SUP2) ? supplyFrame.data2 : 32'h0;

   assign cchit        = cchit_q;
   assign cctrans      = cctrans_q;
   assign snp_way      = snpWay_q;
   assign snp_upd_en   = (state_q == SNP_UPD) && ccwait && !RST;
   assign snp_valid_nx = snp_upd_en && !ccinv;
   assign snp_dirty_nx = 1'b0;
   assign ccdone       = (state_q == SNP_DONE);

   // Both ways holding the same block means the dcache fill logic is broken.
   assert property (@(posedge CLK) disable iff (RST)
      (state_q == SNP_LOOKUP) |-> !(hit0 && hit1))
      else $error("snoop: block present in both ways");

   // Bus controller must hold ccwait until it has seen ccdone.
   assert property (@(posedge CLK) disable iff (RST)
      (state_q inside {SNP_LOOKUP, SNP_SUP1, SNP_SUP2, SNP_UPD}) |-> ccwait)
      else $warning("snoop: ccwait dropped before ccdone");

endmodule
